// File: rtl/sfx_clip_player.sv
// rtl/sfx_clip_player.sv - sound-effect clip player fetching PCM samples from a ROM
//
// Plays the jump / death / win clip selected by audio_select. A clip starts
// whenever audio_select moves to a different non-zero code. Each sample_req
// pulse fetches one 16-bit sample (3-cycle latency); silence (0) is returned
// when no clip is active.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   audio_select  clip code: 00 none, 01/10/11 clip 1/2/3
//   sample_req    one-cycle pulse requesting the next sample
//   rom_addr      registered ROM read address
//   rom_rd        one-cycle ROM read strobe
//   rom_data      ROM data, valid one cycle after rom_rd
//   sample        current output sample, held between updates
//   sample_valid  one-cycle pulse when sample updates
//   playing       high while a clip is active
//   clip_id       code of the active clip, 00 when idle
//   clip_done     one-cycle pulse with the last sample of a clip
module sfx_clip_player #(
    parameter int ADDR_W     = 16,
    parameter int CLIP1_BASE = 0,
    parameter int CLIP1_LEN  = 4000,
    parameter int CLIP2_BASE = 4000,
    parameter int CLIP2_LEN  = 12000,
    parameter int CLIP3_BASE = 16000,
    parameter int CLIP3_LEN  = 16000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        audio_select,
    input  logic              sample_req,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [15:0]       rom_data,
    output logic [15:0]       sample,
    output logic              sample_valid,
    output logic              playing,
    output logic [1:0]        clip_id,
    output logic              clip_done
);

    typedef enum logic [1:0] {IDLE, READY, FETCH, LATCH} state_t;

    localparam logic [ADDR_W-1:0] C1_BASE = ADDR_W'(CLIP1_BASE);
    localparam logic [ADDR_W-1:0] C1_LEN  = ADDR_W'(CLIP1_LEN);
    localparam logic [ADDR_W-1:0] C2_BASE = ADDR_W'(CLIP2_BASE);
    localparam logic [ADDR_W-1:0] C2_LEN  = ADDR_W'(CLIP2_LEN);
    localparam logic [ADDR_W-1:0] C3_BASE = ADDR_W'(CLIP3_BASE);
    localparam logic [ADDR_W-1:0] C3_LEN  = ADDR_W'(CLIP3_LEN);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        sel_prev;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] rem;
    logic              issued;     // the fetch in flight actually read the ROM
    logic              trig_seen;  // a new clip started while that fetch was in flight

    logic [ADDR_W-1:0] code_base;
    logic [ADDR_W-1:0] code_len;
    logic              start;
    logic              accept;
    logic              issue;
    logic              last;
    logic [ADDR_W-1:0] eff_ptr;
    logic [ADDR_W-1:0] eff_rem;
    logic              eff_play;

    always_comb begin
        code_base = '0;
        code_len  = '0;
        case (audio_select)
            2'b01:   begin code_base = C1_BASE; code_len = C1_LEN; end
            2'b10:   begin code_base = C2_BASE; code_len = C2_LEN; end
            2'b11:   begin code_base = C3_BASE; code_len = C3_LEN; end
            default: begin code_base = '0;      code_len = '0;     end
        endcase
    end

    // A zero-length clip is treated as if the code change never happened.
    assign start = (audio_select != 2'b00) && (audio_select != sel_prev) && (code_len != '0);

    // A trigger coinciding with a request must fetch from the new clip, so the
    // read decision looks through to the values being loaded this cycle.
    assign eff_ptr  = start ? code_base : ptr;
    assign eff_rem  = start ? code_len  : rem;
    assign eff_play = start || playing;

    assign accept = ((state == IDLE) || (state == READY)) && sample_req;
    assign issue  = accept && eff_play && (eff_rem != '0);

    // A retrigger at any point after the read was issued (including the latch
    // cycle itself) means the clip has a successor and must not report done.
    assign last = issued && (rem == '0) && !trig_seen && !start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, READY: if (sample_req) state_next = FETCH;
            FETCH:       state_next = LATCH;
            LATCH:       state_next = last ? IDLE : READY;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_prev     <= 2'b00;
            ptr          <= '0;
            rem          <= '0;
            issued       <= 1'b0;
            trig_seen    <= 1'b0;
            rom_addr     <= '0;
            rom_rd       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            playing      <= 1'b0;
            clip_id      <= 2'b00;
            clip_done    <= 1'b0;
        end else begin
            sel_prev     <= audio_select;
            rom_rd       <= 1'b0;
            sample_valid <= 1'b0;
            clip_done    <= 1'b0;

            if (start) begin
                ptr     <= code_base;
                rem     <= code_len;
                clip_id <= audio_select;
                playing <= 1'b1;
                if ((state == FETCH) || (state == LATCH)) begin
                    trig_seen <= 1'b1;
                end
            end

            if (accept) begin
                issued    <= issue;
                trig_seen <= 1'b0;
            end

            // Later assignments override the trigger load above on purpose.
            if (issue) begin
                rom_addr <= eff_ptr;
                rom_rd   <= 1'b1;
                ptr      <= eff_ptr + ONE;
                rem      <= eff_rem - ONE;
            end

            if (state == LATCH) begin
                sample       <= issued ? rom_data : 16'h0000;
                sample_valid <= 1'b1;
                if (last) begin
                    clip_done <= 1'b1;
                    playing   <= 1'b0;
                    clip_id   <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_clip_player.sv
// tb/tb_sfx_clip_player.sv - self-checking bench for sfx_clip_player
module tb_sfx_clip_player;

    localparam int AW  = 16;
    localparam int B1  = 8;
    localparam int L1  = 4;
    localparam int B2  = 100;
    localparam int L2  = 6;
    localparam int B3  = 200;
    localparam int L3  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    audio_select;
    logic          sample_req;
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [15:0]   rom_data = 16'h0000;
    logic [15:0]   sample;
    logic          sample_valid;
    logic          playing;
    logic [1:0]    clip_id;
    logic          clip_done;

    int n_checks = 0;
    int n_fail   = 0;

    sfx_clip_player #(
        .ADDR_W(AW),
        .CLIP1_BASE(B1), .CLIP1_LEN(L1),
        .CLIP2_BASE(B2), .CLIP2_LEN(L2),
        .CLIP3_BASE(B3), .CLIP3_LEN(L3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .audio_select(audio_select),
        .sample_req(sample_req),
        .rom_addr(rom_addr),
        .rom_rd(rom_rd),
        .rom_data(rom_data),
        .sample(sample),
        .sample_valid(sample_valid),
        .playing(playing),
        .clip_id(clip_id),
        .clip_done(clip_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romf(input logic [AW-1:0] a);
        logic [15:0] x;
        x = 16'(a) * 16'd2654 + 16'h1357;
        return x ^ {a[8:0], 7'h55};
    endfunction

    // ROM returns garbage when not read so a missing "silence" path shows up.
    always @(posedge clk) begin
        if (rom_rd) rom_data <= romf(rom_addr);
        else        rom_data <= 16'($urandom);
    end

    function automatic int clen(input logic [1:0] c);
        case (c)
            2'd1:    return L1;
            2'd2:    return L2;
            2'd3:    return L3;
            default: return 0;
        endcase
    endfunction

    function automatic int cbase(input logic [1:0] c);
        case (c)
            2'd1:    return B1;
            2'd2:    return B2;
            2'd3:    return B3;
            default: return 0;
        endcase
    endfunction

    // Reference model: clip position as an index, one pending request.
    logic [1:0]    m_prev;
    logic          m_play;
    logic [1:0]    m_id;
    int            m_idx;
    int            pend_cnt;
    logic [15:0]   pend_data;
    logic          pend_last;

    logic          e_rd, e_valid, e_done, e_play;
    logic [1:0]    e_id;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_sample;

    task automatic model_reset();
        m_prev = 2'b00; m_play = 1'b0; m_id = 2'b00; m_idx = 0;
        pend_cnt = 0; pend_data = '0; pend_last = 1'b0;
        e_rd = 1'b0; e_valid = 1'b0; e_done = 1'b0; e_play = 1'b0;
        e_id = 2'b00; e_addr = '0; e_sample = '0;
    endtask

    task automatic model_step(input logic [1:0] s, input logic r);
        logic trig;
        e_rd = 1'b0; e_valid = 1'b0; e_done = 1'b0;
        trig = (s != 2'b00) && (s != m_prev) && (clen(s) != 0);
        m_prev = s;
        if (trig) begin
            if (pend_cnt > 0) pend_last = 1'b0;
            m_play = 1'b1; m_id = s; m_idx = 0;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                e_valid  = 1'b1;
                e_sample = pend_data;
                if (pend_last) begin
                    e_done = 1'b1; m_play = 1'b0; m_id = 2'b00;
                end
            end
        end else if (r) begin
            if (m_play && m_idx < clen(m_id)) begin
                e_rd      = 1'b1;
                e_addr    = AW'(cbase(m_id) + m_idx);
                m_idx++;
                pend_data = romf(e_addr);
                pend_last = (m_idx == clen(m_id));
            end else begin
                pend_data = '0;
                pend_last = 1'b0;
            end
            pend_cnt = 2;
        end
        e_play = m_play;
        e_id   = m_id;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("rom_rd",       32'(rom_rd),       32'(e_rd));
        check("rom_addr",     32'(rom_addr),     32'(e_addr));
        check("sample",       32'(sample),       32'(e_sample));
        check("sample_valid", 32'(sample_valid), 32'(e_valid));
        check("playing",      32'(playing),      32'(e_play));
        check("clip_id",      32'(clip_id),      32'(e_id));
        check("clip_done",    32'(clip_done),    32'(e_done));
    endtask

    // Drive inputs at a falling edge, advance one rising edge, check at the next falling edge.
    task automatic tick(input logic [1:0] s, input logic r);
        audio_select = s;
        sample_req   = r;
        model_step(s, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) tick(s, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b0;
        audio_select = 2'b00;
        sample_req   = 1'b0;
        model_reset();
        #1;
        check_outputs();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
        end
        reset = 1'b1;
    endtask

    initial begin
        int gap;
        logic [1:0] sel;
        logic req;

        reset = 1'b0; audio_select = 2'b00; sample_req = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Idle request: silence after 3 cycles, no ROM access.
        idle_cycles(2'b00, 3);
        tick(2'b00, 1'b1);
        idle_cycles(2'b00, 5);

        // Full jump clip plus one extra request past its end.
        tick(2'b01, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(2'b01, 1'b1);
            idle_cycles(2'b01, 5);
        end

        // Held code, then return to 00 mid-clip.
        tick(2'b00, 1'b0);
        for (int k = 0; k < 20; k++) tick(2'b01, (k == 0) || (k == 10));
        for (int k = 0; k < 30; k++) tick(2'b00, (k % 6) == 0);

        // Switch 01 -> 10 while a fetch is in flight.
        tick(2'b00, 1'b0);
        tick(2'b01, 1'b1);
        tick(2'b10, 1'b0);
        idle_cycles(2'b10, 4);
        for (int k = 0; k < 8; k++) begin
            tick(2'b10, 1'b1);
            idle_cycles(2'b10, 4);
        end

        // Trigger coinciding with a request.
        idle_cycles(2'b00, 3);
        tick(2'b11, 1'b1);
        idle_cycles(2'b11, 5);

        // Reset one cycle after the read strobe.
        tick(2'b00, 1'b0);
        tick(2'b01, 1'b1);
        tick(2'b01, 1'b0);
        do_reset(2);
        idle_cycles(2'b00, 2);
        tick(2'b00, 1'b1);
        idle_cycles(2'b00, 5);

        // Randomized traffic.
        gap = 10;
        sel = 2'b00;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
            req = (gap >= 4) && ($urandom_range(0, 2) == 0);
            gap = req ? 0 : gap + 1;
            tick(sel, req);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
